// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the single-port memory
//                arbiter: FSM state encoding, port identifiers and the width
//                of the read-latency counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } arb_state_e;

   // Port identifiers used by the round-robin picker and winner register
   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   // Supported memory latency range and the counter width covering it
   localparam int MIN_MEM_LAT = 1;
   localparam int MAX_MEM_LAT = 8;
   localparam int LAT_CNT_W   = $clog2(MAX_MEM_LAT);

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_rr.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_rr
//  Description : Two-way round-robin picker. A lone requester always wins;
//                on a conflict the port that did not win last time wins.
//  Ports       : i_req       - instruction port request
//                d_req       - data port request
//                last_winner - port id of the previous grant
//                win_valid   - at least one request present
//                win_id      - port id of the winner (PORT_I / PORT_D)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_rr
   import mem_arb_pkg::*;
(
   input  logic i_req,
   input  logic d_req,
   input  logic last_winner,
   output logic win_valid,
   output logic win_id
);

   always_comb begin
      win_valid = i_req | d_req;
      if (i_req && d_req) begin
         win_id = ~last_winner;
      end else if (d_req) begin
         win_id = PORT_D;
      end else begin
         win_id = PORT_I;
      end
   end

endmodule : mem_arb_rr
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one synchronous single-port memory between the
//                instruction-fetch port (read only) and the load/store data
//                port. One transaction in flight; conflicts resolved
//                round-robin; each transaction ends with a one-cycle ack,
//                carrying registered read data for reads. All outputs are
//                registers.
//  Ports       : clk, rst               - clock, async active-high reset
//                i_req/i_addr           - instruction read request
//                i_ack/i_rdata          - instruction completion and data
//                d_req/d_we/d_addr/d_wdata - data request
//                d_ack/d_rdata          - data completion and read data
//                m_en/m_we/m_addr/m_wdata - memory command (zero when idle)
//                m_rdata                - memory read data, MEM_LAT after m_en
//                busy                   - FSM not in IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              m_en,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   output logic              busy
);

   if ((MEM_LAT < MIN_MEM_LAT) || (MEM_LAT > MAX_MEM_LAT)) begin : g_bad_mem_lat
      $error("mem_port_arbiter: MEM_LAT must be within 1..8");
   end

   localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LAT - 1);

   arb_state_e             state_q;
   logic [LAT_CNT_W-1:0]   lat_cnt_q;
   // Updated on every grant, so between grant and ack it also identifies the
   // owner of the in-flight transaction.
   logic                   last_winner_q;

   logic                   m_en_q;
   logic                   m_we_q;
   logic [ADDR_W-1:0]      m_addr_q;
   logic [DATA_W-1:0]      m_wdata_q;
   logic                   i_ack_q;
   logic                   d_ack_q;
   logic [DATA_W-1:0]      i_rdata_q;
   logic [DATA_W-1:0]      d_rdata_q;
   logic                   busy_q;

   logic                   arb_valid;
   logic                   arb_id;

   mem_arb_rr u_rr (
      .i_req       (i_req),
      .d_req       (d_req),
      .last_winner (last_winner_q),
      .win_valid   (arb_valid),
      .win_id      (arb_id)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         lat_cnt_q     <= '0;
         last_winner_q <= PORT_D;
         m_en_q        <= 1'b0;
         m_we_q        <= 1'b0;
         m_addr_q      <= '0;
         m_wdata_q     <= '0;
         i_ack_q       <= 1'b0;
         d_ack_q       <= 1'b0;
         i_rdata_q     <= '0;
         d_rdata_q     <= '0;
         busy_q        <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (arb_valid) begin
                  // The memory command registers double as the latched
                  // request fields; they are cleared again after ACCESS.
                  state_q       <= ACCESS;
                  busy_q        <= 1'b1;
                  last_winner_q <= arb_id;
                  m_en_q        <= 1'b1;
                  if (arb_id == PORT_D) begin
                     m_we_q    <= d_we;
                     m_addr_q  <= d_addr;
                     m_wdata_q <= d_we ? d_wdata : '0;
                  end else begin
                     m_we_q    <= 1'b0;
                     m_addr_q  <= i_addr;
                     m_wdata_q <= '0;
                  end
               end
            end

            ACCESS: begin
               m_en_q    <= 1'b0;
               m_we_q    <= 1'b0;
               m_addr_q  <= '0;
               m_wdata_q <= '0;
               if (m_we_q) begin
                  state_q <= RESP;
                  i_ack_q <= 1'b0;
                  d_ack_q <= 1'b1;
               end else begin
                  state_q   <= WAIT;
                  lat_cnt_q <= LAT_LOAD;
               end
            end

            WAIT: begin
               if (lat_cnt_q == '0) begin
                  state_q <= RESP;
                  if (last_winner_q == PORT_D) begin
                     d_rdata_q <= m_rdata;
                     d_ack_q   <= 1'b1;
                  end else begin
                     i_rdata_q <= m_rdata;
                     i_ack_q   <= 1'b1;
                  end
               end else begin
                  lat_cnt_q <= lat_cnt_q - 1'b1;
               end
            end

            RESP: begin
               state_q <= IDLE;
               i_ack_q <= 1'b0;
               d_ack_q <= 1'b0;
               busy_q  <= 1'b0;
            end

            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign m_en    = m_en_q;
   assign m_we    = m_we_q;
   assign m_addr  = m_addr_q;
   assign m_wdata = m_wdata_q;
   assign i_ack   = i_ack_q;
   assign d_ack   = d_ack_q;
   assign i_rdata = i_rdata_q;
   assign d_rdata = d_rdata_q;
   assign busy    = busy_q;

endmodule : mem_port_arbiter
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter for the multicycle RV32 core. It shares one synchronous single-port memory between the instruction-fetch port and the load/store data port, and keeps at most one transaction in flight. Conflicting requests are resolved round-robin. Each request is completed with a one-cycle ack; for reads the ack carries registered read data. It sits between the core's FSM/datapath and the unified memory model.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, memory read latency in cycles (1..8); any other value is an elaboration error
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_req  in  1  instruction read request
- i_addr  in  ADDR_W  instruction address
- i_ack  out  1  instruction transaction complete (one-cycle pulse)
- i_rdata  out  DATA_W  instruction read data, valid with i_ack, held until the next i_ack
- d_req  in  1  data request
- d_we  in  1  data write (1) / read (0)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  data write value
- d_ack  out  1  data transaction complete (one-cycle pulse)
- d_rdata  out  DATA_W  data read value, valid with d_ack on reads, held until the next read d_ack
- m_en  out  1  memory enable
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the enable cycle
- busy  out  1  high when state != IDLE

## Operation
- States: IDLE, ACCESS, WAIT, RESP.
- **IDLE**
  - Samples i_req and d_req.
  - On any request, latches the winner's port, addr, we and wdata, then goes to ACCESS.
  - The instruction port is always a read; d_we matters only for the data port.
- **Arbitration**
  - A single requester wins.
  - When both request, the port that is not last_winner wins.
  - last_winner updates on every grant and resets to the data port, so the instruction port wins the first conflict after reset.
- **ACCESS** (exactly one cycle)
  - m_en=1; m_we, m_addr and m_wdata come from the latched registers.
  - On a write, go to RESP; on a read, load lat_cnt=MEM_LAT-1 and go to WAIT.
- **WAIT**
  - Decrement lat_cnt each cycle.
  - In the cycle lat_cnt==0, capture m_rdata into the winner's rdata register and go to RESP.
  - Duration is MEM_LAT cycles.
- **RESP** (one cycle)
  - Winner's ack=1, then IDLE.
  - Requests are ignored in RESP.
- **Requester rule**
  - Hold req, addr, we and wdata stable from assertion through the ack cycle inclusive.
  - Keeping req high in the cycle after ack issues a new transaction, sampled in IDLE.
- **Read data**
  - The loser's rdata register is untouched.
  - Write completion does not modify d_rdata.
- m_we, m_addr and m_wdata are 0 whenever m_en=0.

## Timing
- Request sampled in IDLE cycle T.
  - Read: m_en in T+1; m_rdata valid in T+1+MEM_LAT; ack in T+2+MEM_LAT; next IDLE in T+3+MEM_LAT.
  - Write: m_en with m_we in T+1; ack in T+2; next IDLE in T+3.
- Reset values: all outputs 0 and all rdata registers 0; state=IDLE, lat_cnt=0, last_winner=data.
- Reset mid-operation (asynchronous abort):
  - m_en, acks and busy drop immediately.
  - An in-flight read is discarded and no ack is issued.
  - A write in ACCESS is not committed, because m_en=0 at the memory's sampling edge.
- Outputs derive only from registers (state and latched fields); there is no combinational path from req to any output.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, WAIT, RESP)
  - port-id constants PORT_I=0, PORT_D=1
  - lat_cnt width, $clog2(8)=3
- Sub-module mem_arb_rr: 2-way round-robin picker (inputs i_req, d_req, last_winner; outputs win_valid, win_id). Everything else lives in the top module.

## Test plan
1. Reset, MEM_LAT=2: hold rst, then release -> all outputs 0, busy=0; first conflict goes to instruction port.
2. i_req, i_addr=0x00400000 in cycle 0; memory returns 0x00000013 in cycle 3 -> m_en=1, m_we=0, m_addr=0x00400000 in cycle 1; i_ack=1, i_rdata=0x00000013 in cycle 4; busy low in cycle 5.
3. d_req, d_we=1, d_addr=0x10010000, d_wdata=0xDEADBEEF in cycle 0 -> m_en=1, m_we=1, m_wdata=0xDEADBEEF in cycle 1; d_ack in cycle 2; d_rdata unchanged; no i_ack.
4. Both ports request continuously, read 0x00400000 and read 0x10010004 -> m_addr sequence 0x00400000 (cycle 1), 0x10010004 (cycle 6), 0x00400000 (cycle 11); strict alternation of acks.
5. Read started in cycle 0, rst asserted in cycle 2 (WAIT) -> m_en/busy 0 immediately, no ack ever; after release a d read completes in MEM_LAT+2 cycles.
6. MEM_LAT=1 vs MEM_LAT=8 single read -> ack in cycle 3 vs cycle 10; i_rdata holds across a later data write ack.
